// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   localparam int unsigned DEF_MEM_BYTES = 1024;

   // Request captured at grant time and replayed onto the memory port.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port bundle for dmem_arbiter.
// master: requester/memory side, slave: the arbiter.
interface dmem_arbiter_if;

   logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// On a tie the requester that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       id
);

   always_comb begin
      gnt = 2'b00;
      id  = 1'b0;
      case (req)
         2'b01: begin gnt = 2'b01; id = 1'b0; end
         2'b10: begin gnt = 2'b10; id = 1'b1; end
         2'b11: begin
            id  = ~last;
            gnt = last ? 2'b01 : 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer of two requesters onto one data-memory port.
// Optional DMEM_ARB_RANGE_CHECK_EN: illegal addresses are sequenced but not issued, and flag err.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   state_e           state, state_nxt;
   logic             last_grant, owner_q;
   req_t             req_q;
   logic [1:0]       req_v, pick_gnt, gnt;
   logic             pick_id;
   logic [1:0]       rvalid_q;
   logic [1:0][31:0] rdata_q;
   logic             legal, in_access;

   assign req_v = {bus.m1_req, bus.m0_req};

   rr_arb2 u_pick (
      .req  (req_v),
      .last (last_grant),
      .gnt  (pick_gnt),
      .id   (pick_id)
   );

   always_comb begin
      state_nxt = state;
      gnt       = 2'b00;
      case (state)
         ST_IDLE: begin
            if (!reset && |req_v) begin
               gnt       = pick_gnt;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

`ifdef DMEM_ARB_RANGE_CHECK_EN
   logic [1:0] err_q;
   assign legal = (req_q.addr < 32'(MEM_BYTES)) && (req_q.addr[1:0] == 2'b00);
`else
   assign legal = 1'b1;
`endif

   // Reset gates the strobes so an access caught by reset never reaches memory.
   assign in_access     = (state == ST_ACCESS) && !reset;
   assign bus.mem_rd    = in_access && !req_q.we && legal;
   assign bus.mem_wr    = in_access &&  req_q.we && legal;
   assign bus.mem_addr  = req_q.addr;
   assign bus.mem_wdata = req_q.wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= REQ_DMA;
         owner_q    <= REQ_CPU;
         req_q      <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         state    <= state_nxt;
         rvalid_q <= '0;
         if (|gnt) begin
            last_grant <= pick_id;
            owner_q    <= pick_id;
            req_q      <= pick_id ? req_t'{bus.m1_we, bus.m1_addr, bus.m1_wdata}
                                  : req_t'{bus.m0_we, bus.m0_addr, bus.m0_wdata};
         end
         if (state == ST_ACCESS) begin
            rvalid_q[owner_q] <= !req_q.we;
            if (!req_q.we) rdata_q[owner_q] <= legal ? bus.mem_rdata : 32'h0;
         end
      end
   end

`ifdef DMEM_ARB_RANGE_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         err_q <= '0;
         if (state == ST_ACCESS) err_q[owner_q] <= !legal;
      end
   end
   assign bus.m0_err = err_q[0];
   assign bus.m1_err = err_q[1];
`else
   assign bus.m0_err = 1'b0;
   assign bus.m1_err = 1'b0;
`endif

   assign bus.m0_gnt    = gnt[0];
   assign bus.m1_gnt    = gnt[1];
   assign bus.m0_rvalid = rvalid_q[0];
   assign bus.m1_rvalid = rvalid_q[1];
   assign bus.m0_rdata  = rdata_q[0];
   assign bus.m1_rdata  = rdata_q[1];

endmodule
